// File: rtl/sccb_responder.sv
// SCCB/I2C register target: decodes bus traffic, ACKs each byte, holds a 256x8 shadow
// register file and strobes every committed write.
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] PID_VAL  = 8'h76,
  parameter logic [7:0] VER_VAL  = 8'h73
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_SUB, S_SUB_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sclSync_q, sdaSync_q;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] subPtr_q, subPtr_d;
  logic       rw_q, rw_d;
  logic       ackOn_q, ackOn_d;
  logic       rdMore_q, rdMore_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wrEn_q, wrEn_d;
  logic [7:0] wrAddr_q, wrAddr_d;
  logic [7:0] wrData_q, wrData_d;
  logic       regWe;
  logic [7:0] regFile_q [256];

  logic       sclHigh, startEv, stopEv, sclRise, sclFall, sdaBit;
  logic [7:0] shiftIn, rdByte;
  logic       protectedAddr;

  // Bit [1] is the synchronized level, bit [2] the previous sample used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclSync_q <= 3'b111;
      sdaSync_q <= 3'b111;
    end else begin
      sclSync_q <= {sclSync_q[1:0], scl_in};
      sdaSync_q <= {sdaSync_q[1:0], sda_in};
    end
  end

  assign sclHigh       = sclSync_q[1] & sclSync_q[2];
  assign startEv       = sclHigh & sdaSync_q[2] & ~sdaSync_q[1];
  assign stopEv        = sclHigh & ~sdaSync_q[2] & sdaSync_q[1];
  assign sclRise       = sclSync_q[1] & ~sclSync_q[2];
  assign sclFall       = ~sclSync_q[1] & sclSync_q[2];
  assign sdaBit        = sdaSync_q[1];
  assign shiftIn       = {shift_q[6:0], sdaBit};
  assign rdByte        = regFile_q[subPtr_q];
  assign protectedAddr = (subPtr_q == 8'h0A) || (subPtr_q == 8'h0B) || (subPtr_q == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      bitCnt_q <= 4'd0;
      shift_q  <= 8'h00;
      subPtr_q <= 8'h00;
      rw_q     <= 1'b0;
      ackOn_q  <= 1'b0;
      rdMore_q <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= 8'h00;
      wrData_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      subPtr_q <= subPtr_d;
      rw_q     <= rw_d;
      ackOn_q  <= ackOn_d;
      rdMore_q <= rdMore_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  // ID registers come up with their fixed values and are never written afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        regFile_q[i] <= (i == 10) ? PID_VAL : (i == 11) ? VER_VAL : 8'h00;
      end
    end else if (regWe) begin
      regFile_q[subPtr_q] <= shift_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    subPtr_d = subPtr_q;
    rw_d     = rw_q;
    ackOn_d  = ackOn_q;
    rdMore_d = rdMore_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    regWe    = 1'b0;

    if (startEv) begin
      state_d  = S_DEV;
      bitCnt_d = 4'd0;
      oe_d     = 1'b0;
      busy_d   = 1'b1;
      ackOn_d  = 1'b0;
      rdMore_d = 1'b0;
    end else if (stopEv) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ackOn_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_DEV, S_SUB, S_WR: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = 4'd0;
              if (state_q == S_SUB) begin
                subPtr_d = shiftIn;
                state_d  = S_SUB_ACK;
              end else if (state_q == S_WR) begin
                state_d = S_WR_ACK;
              end else if (shiftIn[7:1] == DEV_ADDR) begin
                rw_d    = shiftIn[0];
                state_d = S_DEV_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_WAIT_STOP;
              end
            end
          end
        end
        // Each ACK slot spans two SCL falling edges: the first opens it, the second closes it.
        S_DEV_ACK, S_SUB_ACK, S_WR_ACK: begin
          if (sclFall) begin
            if (!ackOn_q) begin
              ackOn_d = 1'b1;
              oe_d    = 1'b1;
              if (state_q == S_WR_ACK) begin
                if (!protectedAddr) begin
                  regWe    = 1'b1;
                  wrEn_d   = 1'b1;
                  wrAddr_d = subPtr_q;
                  wrData_d = shift_q;
                end
                subPtr_d = subPtr_q + 8'd1;
              end
            end else begin
              ackOn_d = 1'b0;
              if (state_q == S_DEV_ACK && rw_q) begin
                oe_d     = ~rdByte[7];
                shift_d  = {rdByte[6:0], 1'b0};
                bitCnt_d = 4'd1;
                state_d  = S_RD;
              end else begin
                oe_d     = 1'b0;
                bitCnt_d = 4'd0;
                state_d  = (state_q == S_DEV_ACK) ? S_SUB : S_WR;
              end
            end
          end
        end
        S_RD: begin
          if (sclFall) begin
            if (bitCnt_q != 4'd8) begin
              oe_d     = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              bitCnt_d = bitCnt_q + 4'd1;
            end else begin
              oe_d     = 1'b0;
              bitCnt_d = 4'd0;
              rdMore_d = 1'b0;
              state_d  = S_RD_ACK;
            end
          end
        end
        S_RD_ACK: begin
          if (sclRise) begin
            if (!sdaBit) begin
              subPtr_d = subPtr_q + 8'd1;
              rdMore_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = S_WAIT_STOP;
            end
          end else if (sclFall && rdMore_q) begin
            rdMore_d = 1'b0;
            oe_d     = ~rdByte[7];
            shift_d  = {rdByte[6:0], 1'b0};
            bitCnt_d = 4'd1;
            state_d  = S_RD;
          end
        end
        S_WAIT_STOP: oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sda_oe      = oe_q;
  assign reg_wr_en   = wrEn_q;
  assign reg_wr_addr = wrAddr_q;
  assign reg_wr_data = wrData_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: an SCCB master model drives the open-drain bus, a table of
// single-write transactions, hand-written corner sequences and randomized traffic against a register model.
module tb_sccb_responder;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sdaM;
  logic       sdaLine;
  logic       sda_oe;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] strobeQ[$];
  logic [15:0] expQ[$];
  logic [7:0]  refMem[256];
  logic [7:0]  refPtr;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [7:0] data;
    logic [2:0] expAcks;
    logic       expStrobe;
    logic       expBusyAfterDev;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  // Wired-AND bus: either side can pull SDA low.
  assign sdaLine = sdaM & ~sda_oe;

  sccb_responder dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl),
    .sda_in     (sdaLine),
    .sda_oe     (sda_oe),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .busy       (busy)
  );

  // Capture every strobed clock cycle; a stretched pulse shows up as extra entries.
  always @(negedge clk) begin
    if (reset && reg_wr_en) strobeQ.push_back({reg_wr_addr, reg_wr_data});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    refMem[8'h0A] = 8'h76;
    refMem[8'h0B] = 8'h73;
    refPtr = 8'h00;
  endtask

  task automatic modelWriteByte(input logic [7:0] d);
    if (!(refPtr inside {8'h0A, 8'h0B, 8'hFF})) begin
      refMem[refPtr] = d;
      expQ.push_back({refPtr, d});
    end
    refPtr = refPtr + 8'd1;
  endtask

  task automatic checkStrobes(input string name);
    checkOutput({name, "_strobe_count"}, strobeQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < strobeQ.size(); i++)
      checkOutput($sformatf("%s_strobe%0d", name, i), strobeQ[i], expQ[i]);
    strobeQ.delete();
    expQ.delete();
  endtask

  task automatic busStart();
    sdaM = 1'b1; #Q;
    scl  = 1'b1; #Q;
    sdaM = 1'b0; #Q;
    scl  = 1'b0; #Q;
  endtask

  task automatic busStop();
    sdaM = 1'b0; #Q;
    scl  = 1'b1; #Q;
    sdaM = 1'b1; #Q;
  endtask

  task automatic sendBit(input logic b);
    sdaM = b; #Q;
    scl  = 1'b1; #Q; #Q;
    scl  = 1'b0; #Q;
  endtask

  task automatic recvBit(output logic b);
    sdaM = 1'b1; #Q;
    scl  = 1'b1; #Q;
    b    = sdaLine; #Q;
    scl  = 1'b0; #Q;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(ack);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic nack, output logic oeAck);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      d[i] = b;
    end
    sdaM  = nack; #Q;
    scl   = 1'b1; #Q;
    oeAck = sda_oe; #Q;
    scl   = 1'b0; #Q;
  endtask

  // One table record = START, device byte, sub-address, one data byte, STOP.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [2:0] acks;
    logic       a;
    string      nm;
    nm = $sformatf("vec%0d", idx);
    strobeQ.delete();
    expQ.delete();
    busStart();
    checkOutput({nm, "_busy_start"}, busy, 1'b1);
    sendByte(v.dev, a);  acks[2] = a;
    checkOutput({nm, "_busy_dev"}, busy, v.expBusyAfterDev);
    sendByte(v.sub, a);  acks[1] = a;
    sendByte(v.data, a); acks[0] = a;
    busStop();
    #(2*Q);
    checkOutput({nm, "_acks"}, acks, v.expAcks);
    checkOutput({nm, "_busy_stop"}, busy, 1'b0);
    if (v.expStrobe) expQ.push_back({v.sub, v.data});
    checkStrobes(nm);
    if (v.dev == 8'h42) begin
      refPtr = v.sub;
      modelWriteByte(v.data);
      expQ.delete();
    end
  endtask

  task automatic writeTxn(input logic [7:0] sub, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n, input string nm);
    logic       a;
    logic       anyNack;
    logic [7:0] bytes[3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    strobeQ.delete();
    expQ.delete();
    busStart();
    sendByte(8'h42, a); anyNack = a;
    sendByte(sub, a);   anyNack |= a;
    refPtr = sub;
    for (int i = 0; i < n; i++) begin
      sendByte(bytes[i], a);
      anyNack |= a;
      modelWriteByte(bytes[i]);
    end
    busStop();
    #(2*Q);
    checkOutput({nm, "_acks"}, anyNack, 1'b0);
    checkStrobes(nm);
  endtask

  task automatic readTxn(input logic [7:0] sub, input int n, input logic repStart, input string nm);
    logic       a;
    logic       anyNack;
    logic       oeAck;
    logic [7:0] d;
    strobeQ.delete();
    expQ.delete();
    busStart();
    sendByte(8'h42, a); anyNack = a;
    sendByte(sub, a);   anyNack |= a;
    refPtr = sub;
    if (!repStart) busStop();
    busStart();
    sendByte(8'h43, a); anyNack |= a;
    for (int i = 0; i < n; i++) begin
      recvByte(d, (i == n - 1), oeAck);
      checkOutput($sformatf("%s_rd%0d", nm, i), d, refMem[refPtr]);
      if (i != n - 1) refPtr = refPtr + 8'd1;
      else checkOutput({nm, "_release"}, oeAck, 1'b0);
    end
    checkOutput({nm, "_busy_nack"}, busy, 1'b0);
    busStop();
    #(2*Q);
    checkOutput({nm, "_acks"}, anyNack, 1'b0);
    checkStrobes(nm);
  endtask

  initial begin
    logic       a;
    logic       oeAck;
    logic [4:0] acks5;
    logic [7:0] d;
    logic [7:0] sub;
    int         n;

    tbl[0] = '{8'h42, 8'h12, 8'h80, 3'b000, 1'b1, 1'b1};
    tbl[1] = '{8'h40, 8'h12, 8'h55, 3'b111, 1'b0, 1'b0};
    tbl[2] = '{8'h42, 8'h0A, 8'h99, 3'b000, 1'b0, 1'b1};
    tbl[3] = '{8'h42, 8'hFF, 8'h77, 3'b000, 1'b0, 1'b1};
    tbl[4] = '{8'h44, 8'h20, 8'h66, 3'b111, 1'b0, 1'b0};
    tbl[5] = '{8'h42, 8'h00, 8'hA5, 3'b000, 1'b1, 1'b1};

    reset = 1'b0;
    scl   = 1'b1;
    sdaM  = 1'b1;
    modelReset();
    #13;
    checkOutput("rst_sda_oe", sda_oe, 1'b0);
    checkOutput("rst_wr_en", reg_wr_en, 1'b0);
    checkOutput("rst_wr_addr", reg_wr_addr, 8'h00);
    checkOutput("rst_wr_data", reg_wr_data, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    #10;
    reset = 1'b1;
    #(2*Q);

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i], i);

    // PID read back after setting the pointer in a separate transaction.
    busStart();
    sendByte(8'h42, a); acks5[0] = a;
    sendByte(8'h0A, a); acks5[1] = a;
    busStop();
    busStart();
    sendByte(8'h43, a); acks5[2] = a;
    recvByte(d, 1'b1, oeAck);
    busStop();
    #(2*Q);
    checkOutput("pid_acks", acks5[2:0], 3'b000);
    checkOutput("pid_data", d, 8'h76);
    checkOutput("pid_release", oeAck, 1'b0);
    checkStrobes("pid");
    refPtr = 8'h0A;

    // Pointer wrap through the discarded FF marker.
    busStart();
    sendByte(8'h42, a); acks5[0] = a;
    sendByte(8'hFE, a); acks5[1] = a;
    sendByte(8'h11, a); acks5[2] = a;
    sendByte(8'h22, a); acks5[3] = a;
    sendByte(8'h33, a); acks5[4] = a;
    busStop();
    #(2*Q);
    checkOutput("wrap_acks", acks5, 5'b00000);
    expQ.push_back({8'hFE, 8'h11});
    expQ.push_back({8'h00, 8'h33});
    checkStrobes("wrap");
    refMem[8'hFE] = 8'h11;
    refMem[8'h00] = 8'h33;
    refPtr = 8'h01;
    readTxn(8'hFF, 2, 1'b1, "wrap_rd");

    // STOP four bits into a data byte must leave the register untouched.
    busStart();
    sendByte(8'h42, a);
    sendByte(8'h3A, a);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    busStop();
    #(2*Q);
    checkStrobes("abort");
    refPtr = 8'h3A;
    readTxn(8'h3A, 1, 1'b0, "abort_rd");
    writeTxn(8'h3A, 8'h04, 8'h00, 8'h00, 1, "abort_wr");
    readTxn(8'h3A, 1, 1'b1, "abort_rd2");

    // Reset while the device-address ACK is being driven.
    busStart();
    for (int i = 7; i >= 0; i--) sendBit(tbl[0].dev[i]);
    #Q;
    checkOutput("rstack_driving", sda_oe, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("rstack_oe_async", sda_oe, 1'b0);
    checkOutput("rstack_busy", busy, 1'b0);
    #19;
    reset = 1'b1;
    modelReset();
    sdaM = 1'b1; #Q;
    scl  = 1'b1; #Q;
    writeTxn(8'h20, 8'h5A, 8'h00, 8'h00, 1, "rstack_wr");
    readTxn(8'h0B, 2, 1'b0, "rstack_rd");

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 4))
        0:       sub = 8'h0A;
        1:       sub = 8'hFE;
        default: sub = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0)
        writeTxn(sub, 8'($urandom), 8'($urandom), 8'($urandom), n, $sformatf("rnd%0d_wr", it));
      else
        readTxn(sub, n, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_rd", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
